// File: rtl/adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell used as the serial datapath of serial_adder.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB first through one full-adder cell, WIDTH cycles per operation.
// Define SERIAL_SUBTRACT_EN to add the i_sub port and A-B support.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
`ifdef SERIAL_SUBTRACT_EN
  input  logic             i_sub,
`endif
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             ready_q;
  logic             valid_q;

  logic             b_bit;
  logic             cin_sel;
  logic             fa_sum;
  logic             fa_co;
  logic             last_bit;
  logic [WIDTH-1:0] sum_d;
  logic [CW-1:0]    cnt_d;

`ifdef SERIAL_SUBTRACT_EN
  logic             sub_q;

  // Subtraction is A + ~B + 1, so B is inverted on its way into the cell.
  assign b_bit   = b_q[0] ^ sub_q;
  assign cin_sel = i_sub ? 1'b1 : i_cin;
`else
  assign b_bit   = b_q[0];
  assign cin_sel = i_cin;
`endif

  full_adder u_fa (
    .a_i (a_q[0]),
    .b_i (b_bit),
    .c_i (carry_q),
    .s_o (fa_sum),
    .c_o (fa_co)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign sum_d    = {fa_sum, sum_q[WIDTH-1:1]};
  assign cnt_d    = cnt_q + CW'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
`ifdef SERIAL_SUBTRACT_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid && ready_q) begin
            a_q     <= i_a;
            b_q     <= i_b;
            carry_q <= cin_sel;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= RUN;
`ifdef SERIAL_SUBTRACT_EN
            sub_q   <= i_sub;
`endif
          end
        end
        RUN: begin
          a_q     <= {1'b0, a_q[WIDTH-1:1]};
          b_q     <= {1'b0, b_q[WIDTH-1:1]};
          carry_q <= fa_co;
          sum_q   <= sum_d;
          if (last_bit) begin
            // carry into the MSB is still in carry_q on this edge
            cout_q  <= fa_co;
            ovf_q   <= carry_q ^ fa_co;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q   <= cnt_d;
          end
        end
        DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_sum   = sum_q;
  assign o_cout  = cout_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder against an arithmetic reference model.
module tb_serial_adder;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_cin;
  logic         i_sub;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_sum;
  logic         o_cout;
  logic         o_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_cin   (i_cin),
`ifdef SERIAL_SUBTRACT_EN
    .i_sub   (i_sub),
`endif
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sum   (o_sum),
    .o_cout  (o_cout),
    .o_ovf   (o_ovf)
  );

  // Drive one operation, check latency and result, hold in DONE, then release.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input int hold, input string tag);
    logic [W:0]   full;
    logic [W-1:0] bb;
    logic         cc;
    logic         eovf;
    longint       tot;
    int           n;
    bb   = sub ? ~b : b;
    cc   = sub ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, bb} + 33'(cc);
    tot  = longint'($signed(a)) + longint'($signed(bb)) + longint'(cc);
    eovf = (tot > 64'sd2147483647) || (tot < -64'sd2147483648);

    n_cmp++;
    if (o_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready_idle: got %b want 1", tag, o_ready);
    end
    i_valid = 1'b1; i_a = a; i_b = b; i_cin = cin; i_sub = sub;
    @(posedge clk); #1;
    i_valid = 1'b0; i_a = $urandom; i_b = $urandom; i_cin = 1'($urandom); i_sub = 1'($urandom);
    n_cmp++;
    if (o_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s ready_run: got %b want 0", tag, o_ready);
    end
    n = 0;
    while (o_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (n != W) begin
      n_bad++;
      $display("FAIL %s latency: got %0d want %0d", tag, n, W);
    end
    n_cmp++;
    if (o_sum !== full[W-1:0]) begin
      n_bad++;
      $display("FAIL %s sum: got %h want %h", tag, o_sum, full[W-1:0]);
    end
    n_cmp++;
    if (o_cout !== full[W]) begin
      n_bad++;
      $display("FAIL %s cout: got %b want %b", tag, o_cout, full[W]);
    end
    n_cmp++;
    if (o_ovf !== eovf) begin
      n_bad++;
      $display("FAIL %s ovf: got %b want %b", tag, o_ovf, eovf);
    end
    for (int k = 0; k < hold; k++) begin
      i_valid = 1'($urandom); i_a = $urandom; i_b = $urandom;
      @(posedge clk); #1;
      n_cmp++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_sum !== full[W-1:0] || o_cout !== full[W]) begin
        n_bad++;
        $display("FAIL %s hold%0d: got v=%b r=%b s=%h c=%b want v=1 r=0 s=%h c=%b",
                 tag, k, o_valid, o_ready, o_sum, o_cout, full[W-1:0], full[W]);
      end
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    n_cmp++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s release: got v=%b r=%b want v=0 r=1", tag, o_valid, o_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_a = '0; i_b = '0; i_cin = 1'b0; i_sub = 1'b0;
    #1;
    n_cmp++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_sum !== '0 || o_cout !== 1'b0 || o_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: got r=%b v=%b s=%h c=%b o=%b want r=1 v=0 s=0 c=0 o=0",
               o_ready, o_valid, o_sum, o_cout, o_ovf);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (o_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release: got r=%b want 1", o_ready);
    end
  endtask

  task automatic test_directed();
    do_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 0, "one_plus_one");
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, "wrap");
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, "pos_ovf");
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 0, "neg_ovf");
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++)
      do_op($urandom, $urandom, 1'($urandom), 1'b0, 0, "random");
  endtask

  task automatic test_backpressure();
    do_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 10, "backpressure");
  endtask

  task automatic test_mid_run_reset();
    i_valid = 1'b1; i_a = 32'hFFFF_FFFF; i_b = 32'h0; i_cin = 1'b0; i_sub = 1'b0;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    n_cmp++;
    if (o_sum === '0) begin
      n_bad++;
      $display("FAIL midrun_partial: got %h want nonzero", o_sum);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_sum !== '0 || o_cout !== 1'b0 || o_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL midrun_reset: got r=%b v=%b s=%h c=%b o=%b want r=1 v=0 s=0 c=0 o=0",
               o_ready, o_valid, o_sum, o_cout, o_ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(32'd3, 32'd4, 1'b0, 1'b0, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++)
      do_op($urandom, $urandom, 1'($urandom), 1'b0, 0, "b2b");
  endtask

`ifdef SERIAL_SUBTRACT_EN
  task automatic test_subtract();
    do_op(32'd5, 32'd7, 1'b0, 1'b1, 0, "sub_5_7");
    for (int k = 0; k < 6; k++)
      do_op($urandom, $urandom, 1'($urandom), 1'b1, 0, "sub_random");
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_mid_run_reset();
    test_back_to_back();
`ifdef SERIAL_SUBTRACT_EN
    test_subtract();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
